// File: rtl/param_sync_fifo.sv
// Single-clock FIFO for any depth >= 2, with programmable almost-full/almost-empty
// thresholds, an occupancy count and an optional first-word-fall-through read port.
module param_sync_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1,
  parameter bit FWFT         = 1'b0,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  AF_C    = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0]  AE_C    = CW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0]  LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack, r_overflow, r_underflow;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

  // All flags derive from the registered count only, so they never disagree.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= AF_C) & ~w_full;
  assign almostempty = ~w_empty & (r_count <= AE_C);
  assign count       = r_count;
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  // Explicit wrap: depth need not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_dout;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_dout <= '0;
      else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
    end
    assign data_out = r_dout;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: A = depth 8 registered read, B = depth 5 wrap, C = depth 8 FWFT with
// thresholds 4/3. All instances share clock and reset.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_din, a_dout, b_din, b_dout, c_din, c_dout;
  logic a_wr, a_rd, b_wr, b_rd, c_wr, c_rd;
  logic a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [3:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;

  param_sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf),
    .full(a_full), .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_cnt));

  param_sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf),
    .full(b_full), .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_cnt));

  param_sync_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .AFULL_LEVEL(4), .AEMPTY_LEVEL(3),
                    .FWFT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .data_out(c_dout), .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf),
    .full(c_full), .empty(c_empty), .almostfull(c_af), .almostempty(c_ae), .count(c_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] exp_w;

  initial begin
    a_din = '0; b_din = '0; c_din = '0;
    a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0; c_wr = 0; c_rd = 0;

    // Reset state
    #1;
    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ae", a_ae, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_pulses", {a_ack, a_ovf, a_udf}, 0);
    chk("rst_c_dout", c_dout, 0);
    #11 rst_n = 1'b1;

    // A: fill 1..8, then overflow
    a_wr = 1;
    for (int i = 1; i <= 8; i++) begin
      a_din = 16'(i);
      tick();
      chk("fill_ack", a_ack, 1);
      chk("fill_count", a_cnt, 32'(i));
      chk("fill_af", a_af, (i >= 6 && i < 8));
      chk("fill_full", a_full, (i == 8));
    end
    a_din = 16'hDEAD;
    tick();
    a_wr = 0;
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_ack", a_ack, 0);
    chk("ovf_count", a_cnt, 8);

    // A: drain 8, then underflow
    a_rd = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("drain_data", a_dout, 32'(i));
      chk("drain_count", a_cnt, 32'(8 - i));
      chk("drain_ae", a_ae, (i == 7));
      chk("drain_empty", a_empty, (i == 8));
      if (i == 1) chk("ovf_clear", a_ovf, 0);
    end
    tick();
    a_rd = 0;
    chk("udf_pulse", a_udf, 1);
    chk("udf_hold_data", a_dout, 16'h0008);
    chk("udf_count", a_cnt, 0);
    tick();
    chk("udf_clear", a_udf, 0);

    // A: simultaneous at full
    a_wr = 1;
    for (int i = 1; i <= 8; i++) begin
      a_din = 16'h0010 + 16'(i);
      tick();
    end
    a_din = 16'hBEEF; a_rd = 1;
    tick();
    a_wr = 0;
    chk("sim_full_count", a_cnt, 7);
    chk("sim_full_ovf", a_ovf, 1);
    chk("sim_full_ack", a_ack, 0);
    chk("sim_full_data", a_dout, 16'h0011);
    for (int i = 0; i < 7; i++) tick();
    a_rd = 0;
    chk("sim_full_last", a_dout, 16'h0018);
    chk("sim_full_empty", a_empty, 1);

    // A: simultaneous at empty
    a_wr = 1; a_rd = 1; a_din = 16'h0077;
    tick();
    a_rd = 0;
    chk("sim_empty_count", a_cnt, 1);
    chk("sim_empty_udf", a_udf, 1);
    chk("sim_empty_ack", a_ack, 1);
    chk("sim_empty_hold", a_dout, 16'h0018);
    a_din = 16'h0078; tick();
    a_din = 16'h0079; tick();

    // A: simultaneous at count 3
    a_rd = 1; a_din = 16'h007A;
    tick();
    a_rd = 0;
    chk("sim_mid_count", a_cnt, 3);
    chk("sim_mid_data", a_dout, 16'h0077);
    chk("sim_mid_flags", {a_ack, a_ovf, a_udf}, 3'b100);
    a_din = 16'h007B; tick();
    a_din = 16'h007C; tick();
    a_wr = 0;
    chk("pre_rst_count", a_cnt, 5);

    // B: depth 5, occupancy 0..4 three times so both pointers wrap
    q.delete();
    for (int r = 0; r < 3; r++) begin
      b_wr = 1;
      for (int k = 0; k < 4; k++) begin
        b_din = 16'h0100 + 16'(r * 4 + k);
        q.push_back(b_din);
        tick();
        chk("wrap_wcount", b_cnt, 32'(q.size()));
        chk("wrap_notfull", b_full, 0);
      end
      b_wr = 0; b_rd = 1;
      for (int k = 0; k < 4; k++) begin
        exp_w = q.pop_front();
        tick();
        chk("wrap_data", b_dout, exp_w);
        chk("wrap_rcount", b_cnt, 32'(q.size()));
      end
      b_rd = 0;
    end
    chk("wrap_empty", b_empty, 1);

    // C: FWFT visibility
    c_din = 16'hA5A5; c_wr = 1;
    chk("fwft_before", c_dout, 0);
    tick();
    c_wr = 0;
    chk("fwft_after", c_dout, 16'hA5A5);
    chk("fwft_count", c_cnt, 1);
    tick();
    chk("fwft_hold", c_dout, 16'hA5A5);
    c_rd = 1;
    tick();
    c_rd = 0;
    chk("fwft_drained", c_dout, 0);
    chk("fwft_empty", c_empty, 1);

    // C: thresholds 4/3 on the way up and down
    c_wr = 1;
    for (int n = 1; n <= 8; n++) begin
      c_din = 16'h00C0 + 16'(n);
      tick();
      chk("thr_up_ae", c_ae, (n <= 3));
      chk("thr_up_af", c_af, (n >= 4 && n <= 7));
      chk("thr_up_full", c_full, (n == 8));
      chk("thr_up_head", c_dout, 16'h00C1);
    end
    c_wr = 0; c_rd = 1;
    for (int n = 7; n >= 0; n--) begin
      tick();
      chk("thr_dn_ae", c_ae, (n >= 1 && n <= 3));
      chk("thr_dn_af", c_af, (n >= 4));
      chk("thr_dn_head", c_dout, (n == 0) ? 16'h0000 : 16'h00C0 + 16'(9 - n));
    end
    c_rd = 0;
    chk("thr_empty", c_empty, 1);

    // A: asynchronous reset between edges at count 5
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", a_cnt, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_dout", a_dout, 0);
    chk("arst_pulses", {a_ack, a_ovf, a_udf}, 0);
    chk("arst_flags", {a_full, a_af, a_ae}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_wr = 1; a_din = 16'h1234;
    tick();
    a_wr = 0; a_rd = 1;
    tick();
    a_rd = 0;
    chk("post_rst_data", a_dout, 16'h1234);
    chk("post_rst_count", a_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
